// File: rtl/modexp_sequencer.sv
// Command sequencer for left-to-right square-and-multiply modular exponentiation.
// It issues INIT/SQUARE/MULTIPLY commands to an external modular multiplier.
module modexp_sequencer #(
    parameter int EXP_W = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [EXP_W-1:0] exponent,
    output logic             mul_req,
    output logic [1:0]       mul_op,
    input  logic             mul_ack,
    output logic [IDX_W-1:0] bit_idx,
    output logic             busy,
    output logic             done,
    output logic [2:0]       state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_SQ   = 3'd2,
        S_MUL  = 3'd3,
        S_GAP  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    localparam logic [1:0] OP_INIT = 2'b00;
    localparam logic [1:0] OP_SQ   = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;

    state_t           state, state_n;
    logic [EXP_W-1:0] exp_q, exp_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             gap_mul, gap_mul_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            exp_q   <= '0;
            idx_q   <= '0;
            gap_mul <= 1'b0;
        end else begin
            state   <= state_n;
            exp_q   <= exp_n;
            idx_q   <= idx_n;
            gap_mul <= gap_mul_n;
        end
    end

    // Handshake: mul_req/mul_op stay stable until mul_ack is sampled high at an
    // edge; that edge completes the command and mul_req drops for at least one
    // cycle (GAP or DONE). mul_ack is ignored whenever mul_req is low.
    always_comb begin
        state_n   = state;
        exp_n     = exp_q;
        idx_n     = idx_q;
        gap_mul_n = gap_mul;
        case (state)
            S_IDLE: begin
                if (start) begin
                    exp_n     = exponent;
                    idx_n     = IDX_W'(EXP_W - 1);
                    gap_mul_n = 1'b0;
                    state_n   = S_INIT;
                end
            end
            S_INIT: begin
                if (mul_ack) begin
                    gap_mul_n = 1'b0;
                    state_n   = S_GAP;
                end
            end
            S_SQ: begin
                if (mul_ack) begin
                    if (exp_q[idx_q]) begin
                        gap_mul_n = 1'b1;
                        state_n   = S_GAP;
                    end else if (idx_q == '0) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n     = idx_q - IDX_W'(1);
                        gap_mul_n = 1'b0;
                        state_n   = S_GAP;
                    end
                end
            end
            S_MUL: begin
                if (mul_ack) begin
                    if (idx_q == '0) begin
                        state_n = S_DONE;
                    end else begin
                        idx_n     = idx_q - IDX_W'(1);
                        gap_mul_n = 1'b0;
                        state_n   = S_GAP;
                    end
                end
            end
            S_GAP:   state_n = gap_mul ? S_MUL : S_SQ;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_comb begin
        mul_req = 1'b0;
        mul_op  = OP_INIT;
        case (state)
            S_INIT: begin mul_req = 1'b1; mul_op = OP_INIT; end
            S_SQ:   begin mul_req = 1'b1; mul_op = OP_SQ;   end
            S_MUL:  begin mul_req = 1'b1; mul_op = OP_MUL;  end
            default: begin mul_req = 1'b0; mul_op = OP_INIT; end
        endcase
    end

    assign busy      = (state != S_IDLE) && (state != S_DONE);
    assign done      = (state == S_DONE);
    assign bit_idx   = idx_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Directed bench for modexp_sequencer at EXP_W=4: command order, latency,
// ack back-pressure, ignored start/ack, mid-run reset and back-to-back starts.
module tb_modexp_sequencer;

    localparam int EXP_W = 4;
    localparam int IDX_W = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [EXP_W-1:0] exponent = '0;
    logic             mul_req;
    logic [1:0]       mul_op;
    logic             mul_ack = 1'b1;
    logic [IDX_W-1:0] bit_idx;
    logic             busy;
    logic             done;
    logic [2:0]       state_dbg;

    modexp_sequencer #(.EXP_W(EXP_W), .IDX_W(IDX_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .exponent  (exponent),
        .mul_req   (mul_req),
        .mul_op    (mul_op),
        .mul_ack   (mul_ack),
        .bit_idx   (bit_idx),
        .busy      (busy),
        .done      (done),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
    endtask

    // Expected commands as {op, bit_idx}; INIT carries the start index.
    logic [3:0] exp_q[$];

    task automatic load_model(input logic [EXP_W-1:0] e);
        exp_q.push_back({2'b00, 2'd3});
        for (int i = EXP_W - 1; i >= 0; i--) begin
            exp_q.push_back({2'b01, 2'(i)});
            if (e[i]) exp_q.push_back({2'b10, 2'(i)});
        end
    endtask

    // ack_mode 0: tied high. 1: ack after 3 waiting cycles, spur_ack while idle.
    int ack_mode = 0;
    bit spur_ack = 1'b0;
    int wait_cnt = 0;

    always @(posedge clk) begin
        #1;
        if (ack_mode == 0) begin
            mul_ack = 1'b1;
            wait_cnt = 0;
        end else if (mul_req) begin
            if (wait_cnt == 3) begin
                mul_ack = 1'b1;
                wait_cnt = 0;
            end else begin
                mul_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mul_ack = spur_ack;
            wait_cnt = 0;
        end
    end

    // Scoreboard on accepted commands plus hold-while-waiting check.
    logic       prev_req = 1'b0;
    logic       prev_ack = 1'b0;
    logic [1:0] prev_op  = '0;
    logic [1:0] prev_idx = '0;

    always @(negedge clk) begin
        if (!reset && mul_req && mul_ack) begin
            logic [3:0] want;
            want = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hF;
            check("cmd", {mul_op, bit_idx}, want);
        end
        if (!reset && prev_req && !prev_ack)
            check("hold", {mul_req, mul_op, bit_idx}, {1'b1, prev_op, prev_idx});
        prev_req = mul_req && !reset;
        prev_ack = mul_ack;
        prev_op  = mul_op;
        prev_idx = bit_idx;
    end

    bit hold_start = 1'b0;

    // Called just after an edge with the DUT in IDLE; returns just after the accepting edge.
    task automatic launch(input logic [EXP_W-1:0] e);
        load_model(e);
        exponent = e;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = hold_start;
        exponent = ~e;
    endtask

    task automatic finish_run(input int lat, input bit pulse);
        int cyc = 0;
        bit seen = 1'b0;
        while (cyc < 400 && !seen) begin
            @(negedge clk);
            cyc++;
            if (done) seen = 1'b1;
            else begin
                check("busy_run", busy, 1);
                if (pulse) start = (cyc % 3 == 1);
            end
        end
        check("latency", cyc, lat);
        check("done_busy", busy, 0);
        check("done_req", mul_req, 0);
        check("done_idx", bit_idx, 0);
        start = hold_start;
        @(posedge clk);
        #1;
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_idx", bit_idx, 0);
        check("sb_empty", exp_q.size(), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_state", state_dbg, 0);
        check("rst_req", mul_req, 0);
        check("rst_op", mul_op, 0);
        check("rst_idx", bit_idx, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_idle", state_dbg, 0);

        // 1011: INIT,SQ3,MUL3,SQ2,SQ1,MUL1,SQ0,MUL0 -> K=8, done at 16
        launch(4'b1011);
        finish_run(16, 1'b0);

        // Zero exponent: INIT + 4 SQ -> K=5, done at 10
        launch(4'b0000);
        finish_run(10, 1'b0);

        // All ones: K=9, done at 18
        launch(4'b1111);
        finish_run(18, 1'b0);

        // 3-cycle ack delay with spurious acks in gaps: 5 cycles per command -> 40
        ack_mode = 1;
        spur_ack = 1'b1;
        launch(4'b1011);
        finish_run(40, 1'b0);
        ack_mode = 0;
        spur_ack = 1'b0;
        @(posedge clk);
        #1;

        // start pulsed while busy has no effect
        launch(4'b1011);
        finish_run(16, 1'b1);

        // Reset while MUL for bit 2 is pending
        begin
            bit found = 1'b0;
            bit saw_done = 1'b0;
            launch(4'b0100);
            for (int i = 0; i < 40 && !found; i++) begin
                @(negedge clk);
                if (mul_req && mul_op == 2'b10 && bit_idx == 2'd2) found = 1'b1;
            end
            check("abort_reached", found, 1);
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
            check("abort_state", state_dbg, 0);
            check("abort_req", mul_req, 0);
            check("abort_op", mul_op, 0);
            check("abort_idx", bit_idx, 0);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                if (done || mul_req) saw_done = 1'b1;
            end
            check("abort_quiet", saw_done, 0);
            exp_q.delete();
            @(posedge clk);
            #1;
        end

        // Fresh run after abort: 0100 -> K=6, done at 12
        launch(4'b0100);
        finish_run(12, 1'b0);

        // Back-to-back with start held: 0001 (K=6) then 1110 re-captured (K=8)
        hold_start = 1'b1;
        launch(4'b0001);
        finish_run(12, 1'b0);
        check("b2b_start_held", start, 1);
        exponent = 4'b1110;
        load_model(4'b1110);
        @(posedge clk);
        #1;
        hold_start = 1'b0;
        finish_run(16, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
